// File: rtl/fp_fma_wb_d.sv
// Writeback buffer for the binary64 FMA result path: canonicalises NaNs,
// classifies each result and queues {value, rd, flags} for the register file.
module fp_fma_wb_d #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_result,
  input  logic [4:0]                in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_data,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_flags,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output logic [15:0]               nan_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  logic [63:0]   data_mem  [DEPTH];
  logic [4:0]    rd_mem    [DEPTH];
  logic [4:0]    flags_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        push;
  logic        pop;
  logic        in_nan;
  logic [63:0] canon;
  logic [4:0]  in_flags;
  logic        exp_ones;
  logic        exp_zero;
  logic        man_zero;

  // Ready and valid derive purely from registered occupancy.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_nan = (in_result[62:52] == '1) && (in_result[51:0] != '0);
  assign canon  = in_nan ? CANON_NAN : in_result;

  always_comb begin
    exp_ones = (canon[62:52] == '1);
    exp_zero = (canon[62:52] == '0);
    man_zero = (canon[51:0] == '0);
    in_flags = '0;
    in_flags[0] = exp_ones & ~man_zero;
    in_flags[1] = exp_zero & ~man_zero;
    in_flags[2] = exp_zero & man_zero;
    in_flags[3] = exp_ones & man_zero;
    in_flags[4] = canon[63] & ~in_flags[0];
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr]  <= canon;
      rd_mem[wr_ptr]    <= in_rd;
      flags_mem[wr_ptr] <= in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      nan_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (push && in_nan && (nan_cnt != '1)) nan_cnt <= nan_cnt + 16'd1;
    end
  end

  always_comb begin
    out_data  = '0;
    out_rd    = '0;
    out_flags = '0;
    if (out_valid) begin
      out_data  = data_mem[rd_ptr];
      out_rd    = rd_mem[rd_ptr];
      out_flags = flags_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fp_fma_wb_d.sv
// Bench for fp_fma_wb_d: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fp_fma_wb_d;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_flags;
  logic        flush;
  logic [2:0]  count;
  logic [15:0] nan_cnt;

  fp_fma_wb_d #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_flags(out_flags),
    .flush(flush), .count(count), .nan_cnt(nan_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of what the register file should see.
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  r;
    logic [4:0]  f;
  } ent_t;

  ent_t q[$];
  int   nanc = 0;

  function automatic logic is_nan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  function automatic ent_t mk(input logic [63:0] v, input logic [4:0] r);
    ent_t e;
    logic [63:0] c;
    c = is_nan(v) ? 64'h7FF8_0000_0000_0000 : v;
    e.d = c;
    e.r = r;
    if (is_nan(c))                                       e.f = 5'b00001;
    else if (c[62:52] == 11'h7FF)                        e.f = {c[63], 4'b1000};
    else if (c[62:52] == 11'd0 && c[51:0] == 52'd0)      e.f = {c[63], 4'b0100};
    else if (c[62:52] == 11'd0)                          e.f = {c[63], 4'b0010};
    else                                                 e.f = {c[63], 4'b0000};
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      nanc = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      logic do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(mk(in_result, in_rd));
        if (is_nan(in_result) && nanc < 16'hFFFF) nanc++;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("m_out_data", out_data, (q.size() != 0) ? q[0].d : 64'd0);
    chk("m_out_rd", 64'(out_rd), (q.size() != 0) ? 64'(q[0].r) : 64'd0);
    chk("m_out_flags", 64'(out_flags), (q.size() != 0) ? 64'(q[0].f) : 64'd0);
    chk("m_nan_cnt", 64'(nan_cnt), 64'(nanc));
  end

  task automatic step(input logic v, input logic [63:0] d, input logic [4:0] r,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_result = d;
    in_rd     = r;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic pop_expect(input logic [4:0] r, input string nm);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk(nm, 64'(out_rd), 64'(r));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v[62:52] = 11'h7FF;
      1: begin v[62:52] = 11'h7FF; v[51:0] = '0; end
      2: begin v[62:52] = 11'd0;   v[51:0] = '0; end
      3: v[62:52] = 11'd0;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nxt_push;
    int exp_pop;
    rst_n = 1'b0;
    in_valid = 0; in_result = '0; in_rd = '0; out_ready = 0; flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_nan_cnt", 64'(nan_cnt), 64'd0);

    step(1, 64'h3FF0_0000_0000_0000, 5'd3, 0, 0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'h3FF0_0000_0000_0000);
    chk("single_rd", 64'(out_rd), 64'd3);
    chk("single_flags", 64'(out_flags), 64'd0);
    pop_expect(5'd3, "single_pop");
    chk("single_empty", 64'(count), 64'd0);

    nb = int'(nan_cnt);
    step(1, 64'hFFF0_0000_0000_0001, 5'd7, 0, 0);
    chk("nan_data", out_data, 64'h7FF8_0000_0000_0000);
    chk("nan_flags", 64'(out_flags), 64'b00001);
    chk("nan_cnt_inc", 64'(nan_cnt), 64'(nb + 1));
    pop_expect(5'd7, "nan_pop");

    for (int i = 1; i <= 4; i++) step(1, 64'h4000_0000_0000_0000, 5'(i), 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    nxt_push = 5;
    exp_pop = 1;
    out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 20 && exp_pop <= 6; i++) begin
      in_valid  = (nxt_push <= 6);
      in_rd     = 5'(nxt_push);
      in_result = 64'hC008_0000_0000_0000;
      if (out_valid) begin
        chk("wrap_order", 64'(out_rd), 64'(exp_pop));
        exp_pop++;
      end
      if (in_valid && in_ready) nxt_push++;
      @(negedge clk);
    end
    chk("wrap_done", 64'(exp_pop), 64'd7);
    step(0, '0, '0, 0, 0);
    chk("wrap_empty", 64'(count), 64'd0);

    step(1, 64'h1, 5'd10, 0, 0);
    step(1, 64'h2, 5'd11, 0, 0);
    chk("sim_pre_count", 64'(count), 64'd2);
    step(1, 64'h3, 5'd12, 1, 0);
    chk("sim_count", 64'(count), 64'd2);
    chk("sim_head", 64'(out_rd), 64'd11);
    step(1, 64'h4, 5'd13, 0, 0);
    step(1, 64'h5, 5'd14, 0, 0);
    chk("sim_full", 64'(in_ready), 64'd0);
    step(1, 64'h6, 5'd15, 1, 0);
    chk("sim_refused_count", 64'(count), 64'd3);
    chk("sim_refused_head", 64'(out_rd), 64'd12);
    pop_expect(5'd12, "sim_pop12");
    pop_expect(5'd13, "sim_pop13");
    pop_expect(5'd14, "sim_pop14");
    chk("sim_drained", 64'(count), 64'd0);

    for (int i = 0; i < 3; i++) step(1, 64'h3FF8_0000_0000_0000, 5'(20 + i), 0, 0);
    nb = int'(nan_cnt);
    step(1, 64'h7FF0_0000_0000_0ABC, 5'd23, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", out_data, 64'd0);
    chk("flush_rd", 64'(out_rd), 64'd0);
    chk("flush_flags", 64'(out_flags), 64'd0);
    chk("flush_nan_cnt", 64'(nan_cnt), 64'(nb));
    step(0, '0, '0, 0, 0);

    step(1, 64'h7FF0_0000_0000_0001, 5'd1, 0, 0);
    step(1, 64'h4010_0000_0000_0000, 5'd2, 0, 0);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_data", out_data, 64'd0);
    chk("arst_rd", 64'(out_rd), 64'd0);
    chk("arst_flags", 64'(out_flags), 64'd0);
    chk("arst_nan_cnt", 64'(nan_cnt), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 64'h8000_0000_0000_0000, 5'd9, 0, 0);
    chk("negzero_flags", 64'(out_flags), 64'b10100);
    chk("negzero_data", out_data, 64'h8000_0000_0000_0000);
    pop_expect(5'd9, "negzero_pop");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), rand_val(), 5'($urandom()),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 8; i++) step(0, '0, '0, 1, 0);
    chk("final_empty", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_fma_wb_d.md
FP_FMA_WB_D -- requirements
Module: fp_fma_wb_d

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries; legal values are powers of two, 2 or greater.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream FMA result is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a result.
REQ-006 SHALL have port in_result, input, 64 bits: IEEE-754 binary64 result from the FMA datapath.
REQ-007 SHALL have port in_rd, input, 5 bits: destination register index.
REQ-008 SHALL have port out_valid, output, 1 bit: writeback entry available.
REQ-009 SHALL have port out_ready, input, 1 bit: register file accepts the entry.
REQ-010 SHALL have port out_data, output, 64 bits: writeback value.
REQ-011 SHALL have port out_rd, output, 5 bits: writeback register index.
REQ-012 SHALL have port out_flags, output, 5 bits: class flags {neg, inf, zero, subnormal, nan}, bit 4 down to bit 0.
REQ-013 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port nan_cnt, output, 16 bits: saturating count of accepted NaN results.

Function
REQ-016 SHALL accept an entry on a rising edge only when in_valid=1 and in_ready=1 (push).
REQ-017 SHALL retire the head entry on a rising edge only when out_valid=1 and out_ready=1 (pop).
REQ-018 SHALL drive in_ready = (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive out_data, out_rd and out_flags from the head entry while out_valid=1, and drive all three to 0 when empty.
REQ-021 SHALL replace any NaN input (exponent all ones, mantissa nonzero) with the canonical NaN 0x7FF8000000000000 at push.
REQ-022 SHALL compute the flags from the canonicalised value at push, as follows:
- nan: exponent all ones and mantissa nonzero.
- inf: exponent all ones and mantissa zero.
- zero: exponent zero and mantissa zero.
- subnormal: exponent zero and mantissa nonzero.
- neg: bit 63 set; always 0 for a NaN.
REQ-023 SHALL store the flags with the entry, so exactly one of nan, inf, zero and subnormal is set, or none of them for a normal value.
REQ-024 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-025 SHALL advance the write and read pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-026 SHALL have a latency of one cycle: a pushed entry is visible on the outputs the cycle after push when the FIFO was empty; there is no bypass.
REQ-027 SHALL, when flush=1, set count to 0 and both pointers to 0 on that edge, dropping any push or pop in that cycle; nan_cnt is unaffected.
REQ-028 SHALL increment nan_cnt on each push of a NaN input, saturating at 0xFFFF; a flushed push is not counted.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force the following, independent of clk:
- count, both pointers and nan_cnt to 0.
- out_valid=0 and in_ready=1.
- out_data, out_rd and out_flags to 0.
REQ-030 SHALL discard in-flight entries on reset mid-operation; FIFO storage contents need not be cleared.

Verification
REQ-031 Single entry: push 0x3FF0000000000000 with rd=3 into an empty FIFO -> next cycle out_valid=1, out_data=0x3FF0000000000000, out_rd=3, out_flags=00000.
REQ-032 NaN canonicalisation: push 0xFFF0000000000001 -> out_data=0x7FF8000000000000, out_flags=00001, nan_cnt increments by 1.
REQ-033 Full and wrap: with out_ready=0, push 4 entries (rd 1..4) -> in_ready=0 and count=4; then with out_ready=1, push 2 more -> pop order is rd 1,2,3,4,5,6 with pointers wrapped.
REQ-034 Simultaneous push and pop at count=2 -> count stays 2 and order is preserved; push attempted at count=4 while popping -> push refused because in_ready=0.
REQ-035 Flush at count=3 with push asserted -> next cycle count=0, out_valid=0, outputs 0, nan_cnt unchanged.
REQ-036 Async reset asserted mid-burst between clock edges -> outputs clear immediately; after release, a push of 0x8000000000000000 -> out_flags=10100.
